// File: rtl/pp_arb_pkg.sv
// Shared types and constants for the ping-pong write-port arbiter.
// Imported by the arbiter top and its beat counter.
package pp_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

   localparam logic OWN_S0 = 1'b0;
   localparam logic OWN_S1 = 1'b1;

   // Bits needed to count 0 .. v-1; v is a power of two >= 2.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pp_burst_counter.sv
// Beat counter for one burst, with a flag marking the final beat of the bank.
// Wraps naturally at BURST_LEN because BURST_LEN is a power of two.
module pp_burst_counter
   import pp_arb_pkg::*;
#(
   parameter int BURST_LEN = 64,
   localparam int BEAT_W = clog2(BURST_LEN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   input  logic              clr,
   output logic [BEAT_W-1:0] cnt,
   output logic              last
);

   logic [BEAT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (inc) begin
         cnt_reg <= cnt_reg + BEAT_W'(1);
      end
   end

   assign cnt  = cnt_reg;
   assign last = (cnt_reg == BEAT_W'(BURST_LEN - 1));

endmodule

// File: rtl/pp_wr_arbiter.sv
// Burst-granular round-robin arbiter sharing the ping-pong buffer write port
// between two sources; each grant lasts exactly one bank (BURST_LEN beats).
module pp_wr_arbiter
   import pp_arb_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int BURST_LEN = 64,
   parameter int CNT_W     = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              arb_en,
   input  logic              s0_req,
   input  logic              s0_valid,
   input  logic [DATA_W-1:0] s0_data,
   output logic              s0_ready,
   output logic              s0_grant,
   input  logic              s1_req,
   input  logic              s1_valid,
   input  logic [DATA_W-1:0] s1_data,
   output logic              s1_ready,
   output logic              s1_grant,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic              burst_done,
   output logic [CNT_W-1:0]  s0_burst_cnt,
   output logic [CNT_W-1:0]  s1_burst_cnt
);

   localparam int BEAT_W = clog2(BURST_LEN);

   arb_state_t        state_reg, state_next;
   logic              owner_reg, owner_next;
   logic              last_owner_reg, last_owner_next;

   logic [1:0]        req_vec;
   logic [1:0]        valid_vec;
   logic [1:0]        ready_vec;
   logic [1:0]        grant_vec;
   logic [DATA_W-1:0] data_arr [2];
   logic [CNT_W-1:0]  burst_cnt_arr [2];

   logic              in_burst;
   logic              handshake;
   logic              last_beat;
   logic              burst_exit;
   logic [BEAT_W-1:0] beat_cnt;

   assign req_vec     = {s1_req, s0_req};
   assign valid_vec   = {s1_valid, s0_valid};
   assign data_arr[0] = s0_data;
   assign data_arr[1] = s1_data;

   assign in_burst   = (state_reg == ST_BURST);
   assign m_valid    = in_burst & valid_vec[owner_reg];
   assign m_data     = in_burst ? data_arr[owner_reg] : '0;
   assign handshake  = m_valid & m_ready;
   assign burst_exit = handshake & last_beat;
   assign burst_done = burst_exit;

   // Counter held at zero outside a burst so an abandoned count can never leak.
   pp_burst_counter #(
      .BURST_LEN (BURST_LEN)
   ) u_beat_counter (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .inc   (handshake),
      .clr   (~in_burst),
      .cnt   (beat_cnt),
      .last  (last_beat)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg      <= ST_IDLE;
         owner_reg      <= OWN_S0;
         last_owner_reg <= OWN_S1;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      case (state_reg)
         ST_IDLE: begin
            if (arb_en && (|req_vec)) begin
               state_next = ST_BURST;
               // On a tie the source that did not own the last burst wins.
               if (&req_vec) begin
                  owner_next = ~last_owner_reg;
               end else begin
                  owner_next = req_vec[1] ? OWN_S1 : OWN_S0;
               end
            end
         end
         ST_BURST: begin
            if (burst_exit) begin
               state_next      = ST_IDLE;
               last_owner_next = owner_reg;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic [CNT_W-1:0] cnt_reg;

         assign grant_vec[gi] = in_burst & (owner_reg == 1'(gi));
         assign ready_vec[gi] = grant_vec[gi] & m_ready;

         always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
               cnt_reg <= '0;
            end else if (burst_exit && (owner_reg == 1'(gi))) begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end

         assign burst_cnt_arr[gi] = cnt_reg;
      end
   endgenerate

   assign s0_grant     = grant_vec[0];
   assign s1_grant     = grant_vec[1];
   assign s0_ready     = ready_vec[0];
   assign s1_ready     = ready_vec[1];
   assign s0_burst_cnt = burst_cnt_arr[0];
   assign s1_burst_cnt = burst_cnt_arr[1];

   // Beats are only ever counted while a burst is in flight.
   assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
                    !in_burst |-> (beat_cnt == '0));

endmodule

// File: tb/tb_pp_wr_arbiter.sv
// Directed self-checking bench for pp_wr_arbiter: single burst, round robin,
// backpressure, source gaps, arb_en gating, counter wrap and async reset.
module tb_pp_wr_arbiter;

   localparam int DATA_W    = 64;
   localparam int BURST_LEN = 64;
   localparam int CNT_W     = 2;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n;
   logic              arb_en;
   logic              s0_req, s0_valid, s0_ready, s0_grant;
   logic [DATA_W-1:0] s0_data;
   logic              s1_req, s1_valid, s1_ready, s1_grant;
   logic [DATA_W-1:0] s1_data;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready;
   logic              burst_done;
   logic [CNT_W-1:0]  s0_burst_cnt, s1_burst_cnt;

   int checks = 0;
   int errors = 0;

   always #10 sys_clk = ~sys_clk;

   pp_wr_arbiter #(
      .DATA_W    (DATA_W),
      .BURST_LEN (BURST_LEN),
      .CNT_W     (CNT_W)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .arb_en       (arb_en),
      .s0_req       (s0_req),
      .s0_valid     (s0_valid),
      .s0_data      (s0_data),
      .s0_ready     (s0_ready),
      .s0_grant     (s0_grant),
      .s1_req       (s1_req),
      .s1_valid     (s1_valid),
      .s1_data      (s1_data),
      .s1_ready     (s1_ready),
      .s1_grant     (s1_grant),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready),
      .burst_done   (burst_done),
      .s0_burst_cnt (s0_burst_cnt),
      .s1_burst_cnt (s1_burst_cnt)
   );

   // Drives one burst for src starting at a negedge where its grant is visible.
   // mode 0: full rate; 1: m_ready 0,1,0,1..; 2: valid gap of 10 at beat 20;
   // 3: arb_en dropped at beat 30; 4: stop after 30 beats (no completion).
   task automatic do_burst(input int src, input int mode, output int cycles);
      int          beat, cyc, gap, limit;
      logic        vld, rdy, exp_done;
      logic        g_own, g_oth, r_own, r_oth;
      logic [63:0] exp_data;
      beat  = 0;
      cyc   = 0;
      gap   = 0;
      limit = (mode == 4) ? 30 : BURST_LEN;
      while (beat < limit && cyc < 400) begin
         rdy      = (mode == 1) ? (cyc % 2 == 1) : 1'b1;
         vld      = !(mode == 2 && beat == 20 && gap < 10);
         exp_data = (64'(src) << 56) | 64'(beat);
         if (mode == 3 && beat == 30) arb_en = 1'b0;
         if (src == 0) begin
            s0_valid = vld;  s0_data = exp_data;
            s1_valid = 1'b1; s1_data = 64'hBAD1_0000_0000_FFFF;
         end else begin
            s1_valid = vld;  s1_data = exp_data;
            s0_valid = 1'b1; s0_data = 64'hBAD0_0000_0000_FFFF;
         end
         m_ready = rdy;
         #1;
         g_own    = (src == 0) ? s0_grant : s1_grant;
         g_oth    = (src == 0) ? s1_grant : s0_grant;
         r_own    = (src == 0) ? s0_ready : s1_ready;
         r_oth    = (src == 0) ? s1_ready : s0_ready;
         exp_done = vld && rdy && (beat == BURST_LEN - 1);
         checks += 6;
         if (g_own !== 1'b1 || g_oth !== 1'b0) begin
            errors++;
            $display("FAIL grant src%0d beat%0d: got own=%b oth=%b, want 1/0", src, beat, g_own, g_oth);
         end
         if (m_valid !== vld) begin
            errors++;
            $display("FAIL m_valid src%0d beat%0d: got %b, want %b", src, beat, m_valid, vld);
         end
         if (m_data !== exp_data) begin
            errors++;
            $display("FAIL m_data src%0d beat%0d: got %h, want %h", src, beat, m_data, exp_data);
         end
         if (r_own !== rdy) begin
            errors++;
            $display("FAIL ready_own src%0d beat%0d: got %b, want %b", src, beat, r_own, rdy);
         end
         if (r_oth !== 1'b0) begin
            errors++;
            $display("FAIL ready_other src%0d beat%0d: got %b, want 0", src, beat, r_oth);
         end
         if (burst_done !== exp_done) begin
            errors++;
            $display("FAIL burst_done src%0d beat%0d: got %b, want %b", src, beat, burst_done, exp_done);
         end
         if (vld && rdy) beat++;
         else if (!vld) gap++;
         @(negedge sys_clk);
         cyc++;
      end
      checks++;
      if (beat < limit) begin
         errors++;
         $display("FAIL burst_timeout src%0d: got %0d beats, want %0d", src, beat, limit);
      end
      if (mode != 4) begin
         #1;
         checks++;
         if (s0_grant !== 1'b0 || s1_grant !== 1'b0 || m_valid !== 1'b0 ||
             m_data !== '0 || burst_done !== 1'b0) begin
            errors++;
            $display("FAIL bubble src%0d: got g0=%b g1=%b mv=%b md=%h bd=%b, want all 0",
                     src, s0_grant, s1_grant, m_valid, m_data, burst_done);
         end
      end
      cycles = cyc;
      $display("burst src=%0d mode=%0d beats=%0d cycles=%0d cnt0=%0d cnt1=%0d",
               src, mode, beat, cyc, s0_burst_cnt, s1_burst_cnt);
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      arb_en = 1'b0; m_ready = 1'b0;
      s0_req = 1'b0; s0_valid = 1'b0; s0_data = '0;
      s1_req = 1'b0; s1_valid = 1'b0; s1_data = '0;
      #25;
      checks++;
      if (s0_grant !== 1'b0 || s1_grant !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0 ||
          m_valid !== 1'b0 || m_data !== '0 || burst_done !== 1'b0 ||
          s0_burst_cnt !== '0 || s1_burst_cnt !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got g=%b%b r=%b%b mv=%b md=%h bd=%b c=%0d/%0d, want all 0",
                  s0_grant, s1_grant, s0_ready, s1_ready, m_valid, m_data, burst_done,
                  s0_burst_cnt, s1_burst_cnt);
      end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      $display("reset released");
   endtask

   task automatic test_single_burst();
      int cyc;
      s0_req = 1'b1; s0_valid = 1'b1; arb_en = 1'b1; m_ready = 1'b1;
      #1;
      checks++;
      if (s0_grant !== 1'b0) begin
         errors++;
         $display("FAIL single_pre_grant: got %b, want 0", s0_grant);
      end
      @(negedge sys_clk);
      checks++;
      if (s0_grant !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: got %b, want 1", s0_grant);
      end
      do_burst(0, 0, cyc);
      s0_req = 1'b0;
      checks += 2;
      if (cyc != 64) begin
         errors++;
         $display("FAIL single_cycles: got %0d, want 64", cyc);
      end
      if (s0_burst_cnt !== 2'd1) begin
         errors++;
         $display("FAIL single_cnt0: got %0d, want 1", s0_burst_cnt);
      end
      @(negedge sys_clk);
      checks++;
      if (s0_grant !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: got %b, want 0", s0_grant);
      end
   endtask

   task automatic test_round_robin();
      int cyc;
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      s0_req = 1'b1; s1_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge sys_clk);
         #1;
         checks++;
         if (s0_grant !== (k != 1) || s1_grant !== (k == 1)) begin
            errors++;
            $display("FAIL rr_grant%0d: got g0=%b g1=%b, want g0=%b g1=%b",
                     k, s0_grant, s1_grant, k != 1, k == 1);
         end
         do_burst((k == 1) ? 1 : 0, 0, cyc);
      end
      s0_req = 1'b0; s1_req = 1'b0;
      checks++;
      if (s0_burst_cnt !== 2'd2 || s1_burst_cnt !== 2'd1) begin
         errors++;
         $display("FAIL rr_counts: got %0d/%0d, want 2/1", s0_burst_cnt, s1_burst_cnt);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      s0_req = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (s0_grant !== 1'b1) begin
         errors++;
         $display("FAIL bp_grant: got %b, want 1", s0_grant);
      end
      s0_req = 1'b0;
      do_burst(0, 1, cyc);
      checks += 2;
      if (cyc != 128) begin
         errors++;
         $display("FAIL bp_cycles: got %0d, want 128", cyc);
      end
      if (s0_burst_cnt !== 2'd3) begin
         errors++;
         $display("FAIL bp_cnt0: got %0d, want 3", s0_burst_cnt);
      end
   endtask

   task automatic test_source_gap();
      int cyc;
      m_ready = 1'b1;
      s1_req = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (s1_grant !== 1'b1) begin
         errors++;
         $display("FAIL gap_grant1: got %b, want 1", s1_grant);
      end
      s1_req = 1'b0; s0_req = 1'b1;
      do_burst(1, 2, cyc);
      checks += 2;
      if (cyc != 74) begin
         errors++;
         $display("FAIL gap_cycles: got %0d, want 74", cyc);
      end
      if (s1_burst_cnt !== 2'd2) begin
         errors++;
         $display("FAIL gap_cnt1: got %0d, want 2", s1_burst_cnt);
      end
      @(negedge sys_clk);
      checks++;
      if (s0_grant !== 1'b1) begin
         errors++;
         $display("FAIL gap_next_grant0: got %b, want 1", s0_grant);
      end
   endtask

   task automatic test_arb_en();
      int cyc;
      s0_req = 1'b0; s1_req = 1'b1;
      do_burst(0, 3, cyc);
      checks += 2;
      if (cyc != 64) begin
         errors++;
         $display("FAIL en_cycles: got %0d, want 64", cyc);
      end
      if (s0_burst_cnt !== 2'd0) begin
         errors++;
         $display("FAIL en_cnt0_wrap: got %0d, want 0", s0_burst_cnt);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge sys_clk);
         checks++;
         if (s0_grant !== 1'b0 || s1_grant !== 1'b0) begin
            errors++;
            $display("FAIL en_hold%0d: got g0=%b g1=%b, want 0/0", k, s0_grant, s1_grant);
         end
      end
      arb_en = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (s1_grant !== 1'b1 || s0_grant !== 1'b0) begin
         errors++;
         $display("FAIL en_resume: got g0=%b g1=%b, want 0/1", s0_grant, s1_grant);
      end
   endtask

   task automatic test_reset_mid_burst();
      int cyc;
      do_burst(1, 4, cyc);
      checks++;
      if (cyc != 30) begin
         errors++;
         $display("FAIL rst_partial_cycles: got %0d, want 30", cyc);
      end
      #5;
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if (s0_grant !== 1'b0 || s1_grant !== 1'b0 || s1_ready !== 1'b0 ||
          m_valid !== 1'b0 || m_data !== '0 || burst_done !== 1'b0 ||
          s0_burst_cnt !== '0 || s1_burst_cnt !== '0) begin
         errors++;
         $display("FAIL rst_async: got g=%b%b r1=%b mv=%b md=%h bd=%b c=%0d/%0d, want all 0",
                  s0_grant, s1_grant, s1_ready, m_valid, m_data, burst_done,
                  s0_burst_cnt, s1_burst_cnt);
      end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      s0_req = 1'b1; s1_req = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (s0_grant !== 1'b1 || s1_grant !== 1'b0) begin
         errors++;
         $display("FAIL rst_first_tie: got g0=%b g1=%b, want 1/0", s0_grant, s1_grant);
      end
      s0_req = 1'b0; s1_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_backpressure();
      test_source_gap();
      test_arb_en();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pp_wr_arbiter.md
Name: pp_wr_arbiter

Overview:
- Burst-granular round-robin arbiter that lets two upstream sources share the single write port of the ping-pong buffer.
- Grant is held for exactly one bank's worth of beats (BURST_LEN), so a bank is always filled by a single source.
- The master side connects directly to the ping-pong buffer's upstream valid/data/ready.

Parameters:
- DATA_W, 64, width of each data beat.
- BURST_LEN, 64, beats per grant; equals the bank depth. Must be a power of 2, ≥2.
- CNT_W, 16, width of the per-source completed-burst counters.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- arb_en  in  1  when low, no new grant is issued; a burst already in flight completes.
- s0_req  in  1  source 0 requests a burst (level).
- s0_valid  in  1  source 0 beat valid.
- s0_data  in  DATA_W  source 0 beat data.
- s0_ready  out  1  source 0 beat accepted.
- s0_grant  out  1  source 0 owns the port.
- s1_req, s1_valid, s1_data, s1_ready, s1_grant: same as the s0_* ports, for source 1.
- m_valid  out  1  to buffer data_en.
- m_data  out  DATA_W  to buffer data_in.
- m_ready  in  1  from buffer o_upstream_ready.
- burst_done  out  1  one-cycle pulse on the last beat handshake of a burst.
- s0_burst_cnt  out  CNT_W  completed bursts from source 0; wraps.
- s1_burst_cnt  out  CNT_W  completed bursts from source 1; wraps.

Behaviour:
- Reset (asynchronous, immediate):
  - State is IDLE, owner = 0, last_owner = 1 (source 0 wins the first tie), beat_cnt = 0.
  - All outputs are 0, including both burst counters.
- State machine, two states:
  - IDLE → BURST on a clock edge where arb_en = 1 and (s0_req | s1_req).
  - Owner selection: if only one source requests, that source; if both request, the source ≠ last_owner.
  - BURST → IDLE on the handshake (m_valid & m_ready) where beat_cnt = BURST_LEN-1.
  - On that exit: last_owner ← owner, beat_cnt ← 0, burst_done = 1 (combinational with the final handshake), winning source's burst counter +1.
- Grant:
  - sN_grant = (state == BURST) & (owner == N). It is registered and appears the cycle after the IDLE decision.
  - Exactly one IDLE cycle separates consecutive bursts; the bubble is intentional.
- Datapath, zero latency, combinational mux:
  - m_valid = BURST & s[owner]_valid.
  - m_data = s[owner]_data in BURST, otherwise 0.
  - s[owner]_ready = BURST & m_ready. The non-owner's ready is 0.
- Beat counter:
  - Width log2(BURST_LEN).
  - Increments only on m_valid & m_ready. Source gaps (valid low) and backpressure (m_ready low) do not advance it.
- Request semantics:
  - req is sampled only in IDLE.
  - Dropping req during BURST is ignored; the burst runs to BURST_LEN beats, and the owner must supply them.
  - No timeout.
- arb_en:
  - Deasserting it mid-burst does not abort the burst.
  - While low in IDLE, the block stays in IDLE and pending requests wait.
- Simultaneous events: last-beat handshake with both reqs high → next grant goes to the other source after the one IDLE cycle.
- Counter wrap: all-ones + 1 → 0, no saturation.
- Reset mid-burst: the burst is abandoned and the beat count is lost. The buffer shares sys_rst_n and resets with it.

Decomposition:
- Package pp_arb_pkg:
  - State enum {ST_IDLE, ST_BURST}.
  - Owner constants OWN_S0 = 0, OWN_S1 = 1.
  - Function for log2(BURST_LEN).
- One sub-module is natural: pp_burst_counter.
  - Beat counter plus last-beat detect.
  - Parameterised by BURST_LEN; inputs inc and clr; outputs cnt and last.
- Arbitration and mux stay inline.

Test Plan:
1. After reset, s0_req=1, s0_valid=1 constantly, m_ready=1, data = beat index → s0_grant rises 1 cycle after req is seen; m_data 0..63 over 64 cycles; burst_done pulses on beat 63; s0_burst_cnt=1; returns to IDLE.
2. s0_req and s1_req both high from reset release → s0 bursts 64 beats, 1 IDLE cycle, then s1 bursts 64 beats, then s0 again; s1_ready=0 throughout s0's bursts.
3. s0 burst with m_ready alternating 1,0 → s0_ready mirrors m_ready; the burst takes 128 cycles; burst_done occurs on the 64th accepted beat only.
4. s1 owns the port, s1_valid=0 for 10 cycles at beat 20 while s0_req=1 → grant is held; m_valid=0; beat_cnt stays at 20; the burst resumes and completes at 64; s0 is then granted.
5. arb_en → 0 at beat 30 of an s0 burst, s1_req=1 → s0 finishes 64 beats; no grant while arb_en=0; s1 is granted 1 cycle after arb_en → 1.
6. sys_rst_n pulsed low at beat 30 of an s1 burst → outputs go to 0 immediately without a clock; counters cleared; after release with both reqs high, s0 wins first.
